// File: rtl/vga_pkg.sv
// Shared constants for the VGA rectangle writer: bus register map, screen
// limits and FSM state encoding.
package vga_pkg;

    localparam int unsigned DefaultXLimit = 160;
    localparam int unsigned DefaultYLimit = 120;

    localparam logic [7:0] AddrX      = 8'hB0;
    localparam logic [7:0] AddrY      = 8'hB1;
    localparam logic [7:0] AddrData   = 8'hB2;
    localparam logic [7:0] AddrRsvd3  = 8'hB3;
    localparam logic [7:0] AddrRsvd4  = 8'hB4;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StWrX    = 3'd1,
        StWrY    = 3'd2,
        StWrD    = 3'd3,
        StSkip   = 3'd4,
        StFinish = 3'd5
    } wr_state_e;

    function automatic logic is_clipped(input logic [8:0]  x,
                                        input logic [7:0]  y,
                                        input int unsigned x_lim,
                                        input int unsigned y_lim);
        return (32'(x) >= x_lim) || (32'(y) >= y_lim);
    endfunction

endpackage

// File: rtl/rect_cursor.sv
// Raster cursor over a rectangle: holds the current (x, y), the row/rect end
// bounds, and exposes the next position so the FSM can pre-decide clipping.
module rect_cursor (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       load,
    input  logic       step,
    input  logic [7:0] x0,
    input  logic [6:0] y0,
    input  logic [7:0] w,
    input  logic [6:0] h,
    output logic [8:0] x,
    output logic [7:0] y,
    output logic [8:0] nxt_x,
    output logic [7:0] nxt_y,
    output logic       end_rect
);

    logic [8:0] x0_q;
    logic [8:0] x_end_q;
    logic [7:0] y_end_q;
    logic       end_row;

    assign end_row  = (x == x_end_q);
    assign end_rect = end_row && (y == y_end_q);

    always_comb begin
        nxt_x = x + 9'd1;
        nxt_y = y;
        if (end_row) begin
            nxt_x = x0_q;
            nxt_y = y + 8'd1;
        end
    end

    // Bounds are garbage for empty rectangles, but the FSM never walks those.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            x       <= '0;
            y       <= '0;
            x0_q    <= '0;
            x_end_q <= '0;
            y_end_q <= '0;
        end else if (load) begin
            x       <= {1'b0, x0};
            y       <= {1'b0, y0};
            x0_q    <= {1'b0, x0};
            x_end_q <= {1'b0, x0} + {1'b0, w} - 9'd1;
            y_end_q <= {1'b0, y0} + {1'b0, h} - 8'd1;
        end else if (step) begin
            x <= nxt_x;
            y <= nxt_y;
        end
    end

endmodule

// File: rtl/vga_rect_writer.sv
// Rectangle fill engine: walks a rectangle in raster order and issues three
// registered bus writes (x, y, pixel) per on-screen pixel.
module vga_rect_writer
    import vga_pkg::*;
#(
    parameter int unsigned X_LIMIT = DefaultXLimit,
    parameter int unsigned Y_LIMIT = DefaultYLimit
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic [7:0] CMD_X,
    input  logic [6:0] CMD_Y,
    input  logic [7:0] CMD_W,
    input  logic [6:0] CMD_H,
    input  logic       CMD_PIXEL,
    output logic [7:0] BUS_ADDR,
    output logic [7:0] BUS_DATA,
    output logic       BUS_WE,
    output logic       BUSY,
    output logic       DONE
);

    wr_state_e  state_q;
    logic [7:0] bus_addr_q;
    logic [7:0] bus_data_q;
    logic       bus_we_q;
    logic       pixel_q;

    logic [8:0] cur_x;
    logic [7:0] cur_y;
    logic [8:0] nxt_x;
    logic [7:0] nxt_y;
    logic       end_rect;
    logic       accept;
    logic       step;

    assign accept = (state_q == StIdle) && CMD_VALID;
    assign step   = ((state_q == StWrD) || (state_q == StSkip)) && !end_rect;

    rect_cursor u_cursor (
        .CLK      (CLK),
        .RESET    (RESET),
        .load     (accept),
        .step     (step),
        .x0       (CMD_X),
        .y0       (CMD_Y),
        .w        (CMD_W),
        .h        (CMD_H),
        .x        (cur_x),
        .y        (cur_y),
        .nxt_x    (nxt_x),
        .nxt_y    (nxt_y),
        .end_rect (end_rect)
    );

    // Bus outputs are loaded alongside the state they belong to, so the first
    // write appears in the cycle right after acceptance.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= StIdle;
            bus_addr_q <= '0;
            bus_data_q <= '0;
            bus_we_q   <= 1'b0;
            pixel_q    <= 1'b0;
        end else begin
            bus_addr_q <= '0;
            bus_data_q <= '0;
            bus_we_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (CMD_VALID) begin
                        pixel_q <= CMD_PIXEL;
                        if (CMD_W == 8'd0 || CMD_H == 7'd0) begin
                            state_q <= StFinish;
                        end else if (is_clipped({1'b0, CMD_X}, {1'b0, CMD_Y}, X_LIMIT, Y_LIMIT)) begin
                            state_q <= StSkip;
                        end else begin
                            state_q    <= StWrX;
                            bus_addr_q <= AddrX;
                            bus_data_q <= CMD_X;
                            bus_we_q   <= 1'b1;
                        end
                    end
                end
                StWrX: begin
                    state_q    <= StWrY;
                    bus_addr_q <= AddrY;
                    bus_data_q <= {1'b0, cur_y[6:0]};
                    bus_we_q   <= 1'b1;
                end
                StWrY: begin
                    state_q    <= StWrD;
                    bus_addr_q <= AddrData;
                    bus_data_q <= {7'b0, pixel_q};
                    bus_we_q   <= 1'b1;
                end
                StWrD, StSkip: begin
                    if (end_rect) begin
                        state_q <= StFinish;
                    end else if (is_clipped(nxt_x, nxt_y, X_LIMIT, Y_LIMIT)) begin
                        state_q <= StSkip;
                    end else begin
                        state_q    <= StWrX;
                        bus_addr_q <= AddrX;
                        bus_data_q <= nxt_x[7:0];
                        bus_we_q   <= 1'b1;
                    end
                end
                StFinish: state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
        end
    end

    assign CMD_READY = (state_q == StIdle);
    assign BUSY      = (state_q != StIdle);
    assign DONE      = (state_q == StFinish);
    assign BUS_ADDR  = bus_addr_q;
    assign BUS_DATA  = bus_data_q;
    assign BUS_WE    = bus_we_q;

endmodule

// File: tb/tb_vga_rect_writer.sv
// Self-checking bench for vga_rect_writer: directed corner cases plus random
// rectangles compared cycle by cycle against a pixel-list reference model.
module tb_vga_rect_writer;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic [7:0] CMD_X;
    logic [6:0] CMD_Y;
    logic [7:0] CMD_W;
    logic [6:0] CMD_H;
    logic       CMD_PIXEL;
    logic [7:0] BUS_ADDR;
    logic [7:0] BUS_DATA;
    logic       BUS_WE;
    logic       BUSY;
    logic       DONE;

    vga_rect_writer dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_X     (CMD_X),
        .CMD_Y     (CMD_Y),
        .CMD_W     (CMD_W),
        .CMD_H     (CMD_H),
        .CMD_PIXEL (CMD_PIXEL),
        .BUS_ADDR  (BUS_ADDR),
        .BUS_DATA  (BUS_DATA),
        .BUS_WE    (BUS_WE),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] obs;

    assign obs = {12'b0, CMD_READY, BUSY, DONE, BUS_WE, BUS_ADDR, BUS_DATA};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] mk(input bit rdy, input bit busy, input bit done,
                                       input bit we, input logic [7:0] a, input logic [7:0] d);
        return {12'b0, rdy, busy, done, we, a, d};
    endfunction

    // Reference: enumerate pixels, one skip cycle per off-screen pixel, three
    // writes per on-screen pixel, then a single DONE cycle.
    task automatic build_model(input int x, input int y, input int w, input int h, input bit p);
        exp_q.delete();
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                int px = x + c;
                int py = y + r;
                if (px >= 160 || py >= 120) begin
                    exp_q.push_back(mk(0, 1, 0, 0, 8'h00, 8'h00));
                end else begin
                    exp_q.push_back(mk(0, 1, 0, 1, 8'hB0, 8'(px)));
                    exp_q.push_back(mk(0, 1, 0, 1, 8'hB1, 8'(py)));
                    exp_q.push_back(mk(0, 1, 0, 1, 8'hB2, {7'b0, p}));
                end
            end
        end
        exp_q.push_back(mk(0, 1, 1, 0, 8'h00, 8'h00));
    endtask

    // Junk commands are held valid while busy; they must not be taken.
    task automatic run_cmd(input string name, input int x, input int y, input int w,
                           input int h, input bit p);
        build_model(x, y, w, h, p);
        @(negedge CLK);
        CMD_VALID = 1'b1;
        CMD_X     = 8'(x);
        CMD_Y     = 7'(y);
        CMD_W     = 8'(w);
        CMD_H     = 7'(h);
        CMD_PIXEL = p;
        @(posedge CLK);
        #1;
        CMD_X     = 8'($urandom);
        CMD_Y     = 7'($urandom);
        CMD_W     = 8'($urandom);
        CMD_H     = 7'($urandom);
        CMD_PIXEL = 1'($urandom);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge CLK);
            check_eq($sformatf("%s c+%0d", name, i + 1), obs, exp_q[i]);
            if (i == exp_q.size() - 1) CMD_VALID = 1'b0;
        end
        @(negedge CLK);
        check_eq({name, " ready"}, obs, mk(1, 0, 0, 0, 8'h00, 8'h00));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "bench timed out");
    end

    initial begin
        RESET     = 1'b1;
        CMD_VALID = 1'b1;
        CMD_X     = 8'd1;
        CMD_Y     = 7'd1;
        CMD_W     = 8'd1;
        CMD_H     = 7'd1;
        CMD_PIXEL = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_eq("reset", obs, mk(1, 0, 0, 0, 8'h00, 8'h00));
        RESET     = 1'b0;
        CMD_VALID = 1'b0;
        @(negedge CLK);
        check_eq("post-reset idle", obs, mk(1, 0, 0, 0, 8'h00, 8'h00));

        run_cmd("single", 5, 7, 1, 1, 1'b1);
        run_cmd("2x2", 10, 20, 2, 2, 1'b0);
        run_cmd("clipped", 159, 119, 2, 2, 1'b1);
        run_cmd("w0", 30, 30, 0, 3, 1'b1);
        run_cmd("h0", 30, 30, 3, 0, 1'b1);
        run_cmd("offscreen", 200, 125, 2, 1, 1'b1);

        // Reset during WR_Y of a 4x4 command.
        @(negedge CLK);
        CMD_VALID = 1'b1;
        CMD_X     = 8'd3;
        CMD_Y     = 7'd4;
        CMD_W     = 8'd4;
        CMD_H     = 7'd4;
        CMD_PIXEL = 1'b1;
        @(posedge CLK);
        #1;
        CMD_VALID = 1'b0;
        @(negedge CLK);
        check_eq("abort wr_x", obs, mk(0, 1, 0, 1, 8'hB0, 8'h03));
        @(negedge CLK);
        check_eq("abort wr_y", obs, mk(0, 1, 0, 1, 8'hB1, 8'h04));
        RESET = 1'b1;
        @(negedge CLK);
        check_eq("abort reset", obs, mk(1, 0, 0, 0, 8'h00, 8'h00));
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check_eq($sformatf("abort quiet %0d", i), obs, mk(1, 0, 0, 0, 8'h00, 8'h00));
        end
        run_cmd("after abort", 50, 60, 2, 1, 1'b1);

        for (int n = 0; n < 40; n++) begin
            int x = $urandom_range(0, 1) ? $urandom_range(150, 165) : $urandom_range(0, 255);
            int y = $urandom_range(0, 1) ? $urandom_range(112, 125) : $urandom_range(0, 127);
            int w = $urandom_range(0, 6);
            int h = $urandom_range(0, 4);
            bit p = 1'($urandom_range(0, 1));
            run_cmd($sformatf("rnd%0d(%0d,%0d,%0dx%0d)", n, x, y, w, h), x, y, w, h, p);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
